// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  localparam logic [1:0] IO_PREFIX_DEF = 2'b11;

  function automatic logic is_io(input logic [1:0] top_bits, input logic [1:0] prefix);
    return (top_bits == prefix);
  endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Starvation counter and grant decision: CPU wins unless DMA has waited
// through STARVE_MAX consecutive CPU grants.
module mem_arb_fairness
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_arb,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  output logic o_grant_dma
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(STARVE_MAX);

  logic [CW-1:0] r_starve_cnt;
  logic          w_at_max;

  assign w_at_max = (r_starve_cnt == MAX_CNT);

  // grant decision, only meaningful while i_arb is high
  always_comb begin
    o_grant_dma = 1'b0;
    if (i_dma_req && (!i_cpu_req || w_at_max)) begin
      o_grant_dma = 1'b1;
    end else begin
      o_grant_dma = 1'b0;
    end
  end

  // count CPU grants taken while DMA is waiting, saturating at the bound
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_dma_req) begin
      r_starve_cnt <= '0;
    end else if (i_arb && o_grant_dma) begin
      r_starve_cnt <= '0;
    end else if (i_arb && !w_at_max) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one external memory/I-O port between the CPU load/store path and a
// read-only DMA requester: IDLE -> ISSUE -> RESP, with back-to-back reissue.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         DATA_W     = 16,
  parameter int         ADDR_W     = 16,
  parameter int         STARVE_MAX = 4,
  parameter logic [1:0] IO_PREFIX  = IO_PREFIX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_adr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ack,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_dma_req,
  input  logic [ADDR_W-1:0] i_dma_adr,
  output logic              o_dma_ack,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_adr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_io_sel
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  owner_e            r_owner;
  logic              r_we;
  logic              r_dma_illegal;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_io_sel;
  logic              r_cpu_ack;
  logic              r_dma_ack;
  logic [ADDR_W-1:0] r_mem_adr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_arb;
  logic              w_other_pend;
  logic              w_grant_dma;
  logic [ADDR_W-1:0] w_win_adr;
  logic              w_win_we;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_io;

  mem_arb_fairness #(
    .STARVE_MAX (STARVE_MAX)
  ) u_fairness (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_arb       (w_arb),
    .i_cpu_req   (i_cpu_req),
    .i_dma_req   (i_dma_req),
    .o_grant_dma (w_grant_dma)
  );

  // in RESP the current winner's own req does not justify a reissue
  always_comb begin
    w_other_pend = 1'b0;
    if (r_owner == OWN_CPU) begin
      w_other_pend = i_dma_req;
    end else begin
      w_other_pend = i_cpu_req;
    end
  end

  always_comb begin
    w_arb       = 1'b0;
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        w_arb       = i_cpu_req || i_dma_req;
        w_state_nxt = w_arb ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: begin
        w_arb       = 1'b0;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_arb       = w_other_pend;
        w_state_nxt = w_arb ? ST_ISSUE : ST_IDLE;
      end
      default: begin
        w_arb       = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_win_adr   = i_cpu_adr;
    w_win_we    = i_cpu_we;
    w_win_wdata = i_cpu_wdata;
    if (w_grant_dma) begin
      w_win_adr   = i_dma_adr;
      w_win_we    = 1'b0;
      w_win_wdata = '0;
    end else begin
      w_win_adr   = i_cpu_adr;
      w_win_we    = i_cpu_we;
      w_win_wdata = i_cpu_wdata;
    end
    w_win_io = is_io(w_win_adr[ADDR_W-1 -: 2], IO_PREFIX);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // winner latch; the address/data registers drive the port directly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner       <= OWN_CPU;
      r_we          <= 1'b0;
      r_dma_illegal <= 1'b0;
      r_mem_adr     <= '0;
      r_mem_wdata   <= '0;
    end else if (w_arb) begin
      r_owner       <= w_grant_dma ? OWN_DMA : OWN_CPU;
      r_we          <= w_win_we;
      r_dma_illegal <= w_grant_dma && w_win_io;
      r_mem_adr     <= w_win_adr;
      r_mem_wdata   <= w_win_wdata;
    end else begin
      r_owner       <= r_owner;
      r_we          <= r_we;
      r_dma_illegal <= r_dma_illegal;
      r_mem_adr     <= r_mem_adr;
      r_mem_wdata   <= r_mem_wdata;
    end
  end

  // strobes are high only during ISSUE; DMA into I/O space gets none
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_en  <= 1'b0;
      r_io_sel  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
    end else begin
      r_mem_en  <= w_arb && !w_win_io;
      r_io_sel  <= w_arb && w_win_io && !w_grant_dma;
      r_mem_we  <= w_arb && w_win_we;
      r_cpu_ack <= (r_state == ST_ISSUE) && (r_owner == OWN_CPU);
      r_dma_ack <= (r_state == ST_ISSUE) && (r_owner == OWN_DMA);
    end
  end

  // read data arrives the cycle after the strobe, so it is steered, not stored
  always_comb begin
    o_cpu_rdata = '0;
    o_dma_rdata = '0;
    if (r_cpu_ack && !r_we) begin
      o_cpu_rdata = i_mem_rdata;
    end else begin
      o_cpu_rdata = '0;
    end
    if (r_dma_ack && !r_dma_illegal) begin
      o_dma_rdata = i_mem_rdata;
    end else begin
      o_dma_rdata = '0;
    end
  end

  assign o_cpu_ack   = r_cpu_ack;
  assign o_dma_ack   = r_dma_ack;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_io_sel    = r_io_sel;
  assign o_mem_adr   = r_mem_adr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
